// File: rtl/fifo_key_ctrl.sv
// Pushbutton front end for a FIFO: synchronizes and debounces a write and a read
// button, and turns each accepted press into one registered strobe or reject pulse.

module fifo_key_deb #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_fire
);

  typedef enum logic [2:0] {IDLE, DEB_PRESS, FIRE, HELD, DEB_REL} state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             w_btn_s;
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;

  assign w_btn_s = r_sync[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // o_fire marks the edge that enters FIRE; the parent registers its outputs there
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    o_fire     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_btn_s) begin
          w_next     = DEB_PRESS;
          w_cnt_next = '0;
        end
      end
      DEB_PRESS: begin
        if (!w_btn_s) begin
          w_next = IDLE;
        end else if (r_cnt == LP_LAST) begin
          w_next = FIRE;
          o_fire = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      FIRE: w_next = HELD;
      HELD: begin
        if (!w_btn_s) begin
          w_next     = DEB_REL;
          w_cnt_next = '0;
        end
      end
      DEB_REL: begin
        if (w_btn_s) begin
          w_next = HELD;
        end else if (r_cnt == LP_LAST) begin
          w_next = IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

module fifo_key_ctrl #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_wr,
  input  logic             btn_rd,
  input  logic [WIDTH-1:0] sw_data,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             write,
  output logic             read,
  output logic [WIDTH-1:0] fifo_in,
  output logic             wr_reject,
  output logic             rd_reject
);

  logic w_wr_fire, w_rd_fire;
  logic r_write, r_read, r_wr_reject, r_rd_reject;
  logic [WIDTH-1:0] r_fifo_in;

  fifo_key_deb #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_wr (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_btn   (btn_wr),
    .o_fire  (w_wr_fire)
  );

  fifo_key_deb #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_rd (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_btn   (btn_rd),
    .o_fire  (w_rd_fire)
  );

  // Flags are looked at only on the FIRE-entry edge, so later flag changes cannot retrigger
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_write     <= 1'b0;
      r_read      <= 1'b0;
      r_wr_reject <= 1'b0;
      r_rd_reject <= 1'b0;
      r_fifo_in   <= '0;
    end else begin
      r_write     <= w_wr_fire & ~fifo_full;
      r_wr_reject <= w_wr_fire &  fifo_full;
      r_read      <= w_rd_fire & ~fifo_empty;
      r_rd_reject <= w_rd_fire &  fifo_empty;
      if (w_wr_fire && !fifo_full) begin
        r_fifo_in <= sw_data;
      end
    end
  end

  assign write     = r_write;
  assign read      = r_read;
  assign wr_reject = r_wr_reject;
  assign rd_reject = r_rd_reject;
  assign fifo_in   = r_fifo_in;

endmodule

// File: tb/tb_fifo_key_ctrl.sv
// Bench for fifo_key_ctrl: table of clean presses, hand-written corner sequences and
// random bouncing buttons checked against a run-length debounce model.

module tb_fifo_key_ctrl;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_wr = 1'b0, btn_rd = 1'b0;
  logic [3:0] sw_data = '0;
  logic       fifo_full = 1'b0, fifo_empty = 1'b0;
  logic       write, read, wr_reject, rd_reject;
  logic [3:0] fifo_in;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_key_ctrl #(.WIDTH(4), .DEB_CYCLES(DEB), .CNT_W(8)) dut (
    .clock      (clk),
    .reset      (rst_n),
    .btn_wr     (btn_wr),
    .btn_rd     (btn_rd),
    .sw_data    (sw_data),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .write      (write),
    .read       (read),
    .fifo_in    (fifo_in),
    .wr_reject  (wr_reject),
    .rd_reject  (rd_reject)
  );

  // Model: a press is accepted after DEB+1 consecutive high synchronized samples,
  // the sample right after acceptance is ignored, release needs DEB+1 low samples.
  bit   ms1[2], ms2[2], mdown[2], mign[2];
  int   mrun[2];
  logic e_write, e_read, e_wrr, e_rdr;
  logic [3:0] e_fin;

  task automatic model_clear();
    for (int b = 0; b < 2; b++) begin
      ms1[b] = 0; ms2[b] = 0; mdown[b] = 0; mign[b] = 0; mrun[b] = 0;
    end
    e_write = 0; e_read = 0; e_wrr = 0; e_rdr = 0; e_fin = '0;
  endtask

  task automatic model_edge();
    bit f[2];
    bit raw[2];
    bit s;
    raw[0] = btn_wr;
    raw[1] = btn_rd;
    for (int b = 0; b < 2; b++) begin
      f[b] = 0;
      s = ms2[b];
      if (mign[b]) begin
        mign[b] = 0;
        mrun[b] = 0;
      end else if (!mdown[b]) begin
        if (s) begin
          mrun[b]++;
          if (mrun[b] == DEB + 1) begin
            f[b] = 1; mdown[b] = 1; mign[b] = 1; mrun[b] = 0;
          end
        end else mrun[b] = 0;
      end else begin
        if (!s) begin
          mrun[b]++;
          if (mrun[b] == DEB + 1) begin
            mdown[b] = 0; mrun[b] = 0;
          end
        end else mrun[b] = 0;
      end
    end
    e_write = f[0] && !fifo_full;
    e_wrr   = f[0] && fifo_full;
    e_read  = f[1] && !fifo_empty;
    e_rdr   = f[1] && fifo_empty;
    if (e_write) e_fin = sw_data;
    for (int b = 0; b < 2; b++) begin
      ms2[b] = ms1[b];
      ms1[b] = raw[b];
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {write, read, wr_reject, rd_reject, fifo_in};
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("model", outs(), {e_write, e_read, e_wrr, e_rdr, e_fin});
  endtask

  typedef struct {
    logic       wr, rd;
    logic [3:0] sw;
    logic       full, empty;
    logic       e_w, e_r, e_wrr, e_rdr;
    logic [3:0] e_fin;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA};
    tbl[1] = '{1'b1, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA};
    tbl[2] = '{1'b0, 1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hA};
    tbl[3] = '{1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA};
    tbl[4] = '{1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3};
    tbl[5] = '{1'b1, 1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3};
    tbl[6] = '{1'b1, 1'b0, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h6};

    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", outs(), 8'h00);
    rst_n = 1'b1;
    repeat (4) step();

    // bouncing write button never settles long enough
    for (int i = 0; i < 20; i++) begin
      btn_wr = (i < 8) ? ~btn_wr : 1'b0;
      step();
      chk("bounce_quiet", {6'b0, write, wr_reject}, 8'h00);
    end

    // clean presses; flags flip after FIRE to show they are not re-sampled
    for (int t = 0; t < 7; t++) begin
      btn_wr = tbl[t].wr;  btn_rd = tbl[t].rd;  sw_data = tbl[t].sw;
      fifo_full = tbl[t].full;  fifo_empty = tbl[t].empty;
      for (int c = 0; c < 20; c++) begin
        step();
        if (c == DEB + 2)
          chk("vec_pulse", outs(), {tbl[t].e_w, tbl[t].e_r, tbl[t].e_wrr, tbl[t].e_rdr, tbl[t].e_fin});
        else
          chk("vec_quiet", {4'b0, write, read, wr_reject, rd_reject}, 8'h00);
        if (c == DEB + 3) begin
          fifo_full = ~fifo_full;
          fifo_empty = ~fifo_empty;
        end
      end
      btn_wr = 1'b0; btn_rd = 1'b0;
      repeat (12) step();
    end

    // reset during DEB_PRESS with the button held through release
    btn_wr = 1'b1; sw_data = 4'h9; fifo_full = 1'b0; fifo_empty = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("rst_async", outs(), 8'h00);
    model_clear();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold", outs(), 8'h00);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 14; c++) begin
      step();
      chk("rst_rewrite", {7'b0, write}, {7'b0, (c == DEB + 2) ? 1'b1 : 1'b0});
    end
    btn_wr = 1'b0;
    repeat (12) step();

    // random bouncing buttons and flags
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0) btn_wr = ~btn_wr;
      if ($urandom_range(7) == 0) btn_rd = ~btn_rd;
      fifo_full  = ($urandom_range(3) == 0);
      fifo_empty = ($urandom_range(3) == 0);
      sw_data    = 4'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
